// File: rtl/fast_pulse_queue_pkg.sv
// Shared types and constants for the fast-domain pulse queue.
package fast_pulse_queue_pkg;

    typedef enum logic [1:0] {
        READY   = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } fpq_state_e;

    localparam int DROP_CNT_W = 8;

    function automatic int tmo_w(input int hi_tmo);
        return $clog2(hi_tmo + 1);
    endfunction

endpackage

// File: rtl/fast_pulse_queue_if.sv
// Event/handshake bundle between the event source, the queue and the synchronizer.
interface fast_pulse_queue_if #(
    parameter int CNT_W = 4
);
    import fast_pulse_queue_pkg::*;

    logic                  evt_in;
    logic                  flush;
    logic                  busy;
    logic                  ovf_clr;
    logic                  sync_pulse;
    logic [CNT_W-1:0]      pending;
    logic                  full;
    logic                  empty;
    logic                  ovf_sticky;
    logic [DROP_CNT_W-1:0] drop_cnt;

    modport master (
        output evt_in, flush, busy, ovf_clr,
        input  sync_pulse, pending, full, empty, ovf_sticky, drop_cnt
    );

    modport slave (
        input  evt_in, flush, busy, ovf_clr,
        output sync_pulse, pending, full, empty, ovf_sticky, drop_cnt
    );

endinterface

// File: rtl/fast_pulse_queue_sat_cnt.sv
// Saturating up/down counter with synchronous clear; UP_ONLY ignores dec_i.
module sat_updown_cnt #(
    parameter int W       = 4,
    parameter bit UP_ONLY = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o
);
    localparam logic [W-1:0] MAX_V = '1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         dec;

    assign dec = dec_i && !UP_ONLY;

    // Simultaneous inc and dec cancel, so a full counter still absorbs an event while issuing.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && !dec && cnt_q != MAX_V)
            cnt_d = cnt_q + W'(1);
        else if (dec && !inc_i && cnt_q != '0)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fast_pulse_queue.sv
// Pending-event queue pacing one pulse at a time into the fast-to-slow synchronizer.
// Build option: FAST_PULSE_QUEUE_DROP_CNT_EN adds the saturating dropped-event counter.
module fast_pulse_queue
    import fast_pulse_queue_pkg::*;
#(
    parameter int CNT_W  = 4,
    parameter int HI_TMO = 4
) (
    input logic              clk_fast,
    input logic              rst_fast,
    fast_pulse_queue_if.slave q
);
    localparam int              TW       = tmo_w(HI_TMO);
    localparam logic [TW-1:0]   TMO_LOAD = TW'(HI_TMO - 1);

    fpq_state_e       state_q;
    logic [TW-1:0]    tmr_q;
    logic             sync_pulse_q;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] pend;
    logic             full_w;
    logic             issue;
    logic             drop;

    assign full_w = (pend == {CNT_W{1'b1}});

    // A flushed cycle issues nothing: the event that would go out is part of what is discarded.
    assign issue = (state_q == READY) && (pend != '0) && !q.busy && !q.flush;
    assign drop  = q.evt_in && !q.flush && full_w && !issue;
    assign ovf_d = drop | (ovf_q & ~q.ovf_clr);

    sat_updown_cnt #(.W(CNT_W), .UP_ONLY(1'b0)) u_pend (
        .clk   (clk_fast),
        .rst   (rst_fast),
        .clr_i (q.flush),
        .inc_i (q.evt_in),
        .dec_i (issue),
        .cnt_o (pend)
    );

    always_ff @(posedge clk_fast) begin
        if (rst_fast) begin
            state_q      <= READY;
            tmr_q        <= '0;
            sync_pulse_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            sync_pulse_q <= issue;
            ovf_q        <= ovf_d;
            case (state_q)
                READY: begin
                    if (issue) begin
                        state_q <= WAIT_HI;
                        tmr_q   <= TMO_LOAD;
                    end
                end
                WAIT_HI: begin
                    if (q.busy)
                        state_q <= WAIT_LO;
                    else if (tmr_q == '0)
                        state_q <= READY;
                    else
                        tmr_q <= tmr_q - TW'(1);
                end
                WAIT_LO: begin
                    if (!q.busy)
                        state_q <= READY;
                end
                default: state_q <= READY;
            endcase
        end
    end

    assign q.sync_pulse = sync_pulse_q;
    assign q.pending    = pend;
    assign q.full       = full_w;
    assign q.empty      = (pend == '0);
    assign q.ovf_sticky = ovf_q;

`ifdef FAST_PULSE_QUEUE_DROP_CNT_EN
    sat_updown_cnt #(.W(DROP_CNT_W), .UP_ONLY(1'b1)) u_drop (
        .clk   (clk_fast),
        .rst   (rst_fast),
        .clr_i (q.ovf_clr),
        .inc_i (drop),
        .dec_i (1'b0),
        .cnt_o (q.drop_cnt)
    );
`else
    assign q.drop_cnt = '0;
`endif

endmodule

// File: tb/tb_fast_pulse_queue.sv
// Self-checking bench for fast_pulse_queue: directed scenarios plus randomized traffic vs a timestamp model.
module tb_fast_pulse_queue;
    localparam int CNT_W  = 4;
    localparam int HI_TMO = 4;
    localparam int MAXP   = 15;
`ifdef FAST_PULSE_QUEUE_DROP_CNT_EN
    localparam bit DCNT_EN = 1'b1;
`else
    localparam bit DCNT_EN = 1'b0;
`endif

    logic clk_fast = 1'b0;
    logic rst_fast = 1'b1;

    fast_pulse_queue_if #(.CNT_W(CNT_W)) q();

    fast_pulse_queue #(.CNT_W(CNT_W), .HI_TMO(HI_TMO)) dut (
        .clk_fast (clk_fast),
        .rst_fast (rst_fast),
        .q        (q)
    );

    always #5 clk_fast = ~clk_fast;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: queue depth plus the first cycle at which the link may carry another pulse.
    int cyc = 0, free_at = 0, b_start = 0, b_end = 0;
    int fixed_d = -1, fixed_l = -1;
    int m_pend = 0, m_dcnt = 0;
    bit m_ovf = 1'b0, m_pulse = 1'b0;
    int npulse = 0, last_p = -1, min_sp = 1000, peak = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d want %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic clr_stats();
        npulse = 0; last_p = -1; min_sp = 1000; peak = 0;
    endtask

    task automatic cycle(input bit e, input bit f, input bit c, input bit fb, input bit r);
        bit b, iss, drop;
        int d, len, p;
        b = fb || (cyc >= b_start && cyc < b_end);
        rst_fast  = r;
        q.evt_in  = e;
        q.flush   = f;
        q.ovf_clr = c;
        q.busy    = b;
        if (r) begin
            m_pend = 0; m_ovf = 1'b0; m_dcnt = 0; m_pulse = 1'b0;
            free_at = 0; b_start = 0; b_end = 0;
        end else begin
            iss  = (cyc >= free_at) && (m_pend > 0) && !b && !f;
            drop = e && !f && (m_pend == MAXP) && !iss;
            m_pulse = iss;
            if (f) m_pend = 0;
            else   m_pend = m_pend + ((e && !drop) ? 1 : 0) - (iss ? 1 : 0);
            if (drop)   m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
            if (c) m_dcnt = 0;
            else if (drop && m_dcnt < 255) m_dcnt++;
            if (iss) begin
                // Downstream model: busy rises d cycles after the pulse for len cycles; d==HI_TMO means never.
                p   = cyc + 1;
                d   = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, HI_TMO));
                len = (fixed_l > 0) ? fixed_l : int'($urandom_range(1, 7));
                if (d < HI_TMO) begin
                    b_start = p + d; b_end = p + d + len; free_at = b_end + 1;
                end else begin
                    b_start = 0; b_end = 0; free_at = p + HI_TMO;
                end
            end
        end
        @(posedge clk_fast);
        #1;
        cyc++;
        chk("pulse",    int'(q.sync_pulse), int'(m_pulse));
        chk("pending",  int'(q.pending),    m_pend);
        chk("full",     int'(q.full),       (m_pend == MAXP) ? 1 : 0);
        chk("empty",    int'(q.empty),      (m_pend == 0) ? 1 : 0);
        chk("ovf",      int'(q.ovf_sticky), int'(m_ovf));
        chk("drop_cnt", int'(q.drop_cnt),   DCNT_EN ? m_dcnt : 0);
        if (q.sync_pulse) begin
            if (last_p >= 0 && (cyc - last_p) < min_sp) min_sp = cyc - last_p;
            last_p = cyc;
            npulse++;
        end
        if (int'(q.pending) > peak) peak = int'(q.pending);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        q.evt_in = 1'b0; q.flush = 1'b0; q.ovf_clr = 1'b0; q.busy = 1'b0;

        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        chk("rst_pending", int'(q.pending), 0);
        chk("rst_empty",   int'(q.empty), 1);
        chk("rst_full",    int'(q.full), 0);
        chk("rst_pulse",   int'(q.sync_pulse), 0);
        chk("rst_ovf",     int'(q.ovf_sticky), 0);
        chk("rst_drop",    int'(q.drop_cnt), 0);

        // Single event with a 6-cycle busy one cycle after the pulse
        fixed_d = 1; fixed_l = 6;
        cycle(1, 0, 0, 0, 0);
        chk("single_pend1", int'(q.pending), 1);
        cycle(0, 0, 0, 0, 0);
        chk("single_pulse", int'(q.sync_pulse), 1);
        chk("single_pend0", int'(q.pending), 0);
        cycle(0, 0, 0, 0, 0);
        chk("single_width", int'(q.sync_pulse), 0);
        idle(10);
        chk("single_empty", int'(q.empty), 1);

        // Burst of five
        clr_stats();
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 0);
        idle(60);
        chk("burst_count",   npulse, 5);
        chk("burst_peak",    peak, 4);
        chk("burst_spacing", min_sp, 9);
        chk("burst_ovf",     int'(q.ovf_sticky), 0);

        // Saturation with busy held high
        cycle(0, 0, 0, 0, 1);
        for (int i = 0; i < 18; i++) cycle(1, 0, 0, 1, 0);
        chk("sat_pending", int'(q.pending), 15);
        chk("sat_full",    int'(q.full), 1);
        chk("sat_ovf",     int'(q.ovf_sticky), 1);
        chk("sat_drop",    int'(q.drop_cnt), DCNT_EN ? 3 : 0);

        // Event coincident with an issue at full, then flush with event
        cycle(1, 0, 0, 0, 0);
        chk("simul_pending", int'(q.pending), 15);
        chk("simul_pulse",   int'(q.sync_pulse), 1);
        chk("simul_drop",    int'(q.drop_cnt), DCNT_EN ? 3 : 0);
        cycle(1, 1, 0, 0, 0);
        chk("flush_pending", int'(q.pending), 0);
        chk("flush_drop",    int'(q.drop_cnt), DCNT_EN ? 3 : 0);
        idle(12);
        cycle(0, 0, 1, 0, 0);
        chk("clr_ovf",  int'(q.ovf_sticky), 0);
        chk("clr_drop", int'(q.drop_cnt), 0);

        // Busy never rises: timeout releases the link
        cycle(0, 0, 0, 0, 1);
        fixed_d = HI_TMO;
        clr_stats();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        idle(20);
        chk("tmo_count",   npulse, 2);
        chk("tmo_spacing", min_sp, HI_TMO + 1);

        // Reset while waiting for busy to fall
        cycle(0, 0, 0, 0, 1);
        fixed_d = 1; fixed_l = 20;
        for (int i = 0; i < 8; i++) cycle(1, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        idle(3);
        chk("wlo_pending", int'(q.pending), 7);
        cycle(0, 0, 0, 0, 1);
        chk("wlo_rst_pending", int'(q.pending), 0);
        chk("wlo_rst_pulse",   int'(q.sync_pulse), 0);
        chk("wlo_rst_ovf",     int'(q.ovf_sticky), 0);
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        chk("wlo_ready_pulse", int'(q.sync_pulse), 1);

        // Randomized traffic
        fixed_d = -1; fixed_l = -1;
        for (int i = 0; i < 3000; i++) begin
            int ph;
            bit e, f, c, fb, r;
            ph = (i / 200) % 3;
            case (ph)
                0:       e = ($urandom_range(0, 1) == 0);
                1:       e = ($urandom_range(0, 7) != 0);
                default: e = ($urandom_range(0, 7) == 0);
            endcase
            f  = ($urandom_range(0, 39) == 0);
            c  = ($urandom_range(0, 15) == 0);
            fb = (cyc >= free_at) && ($urandom_range(0, 5) == 0);
            r  = ($urandom_range(0, 499) == 0);
            cycle(e, f, c, fb, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
